// File: rtl/hififo_pkg.sv
// hififo_pkg: state encoding and half-select helper shared by FIFO width converters
package hififo_pkg;
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;
  function automatic logic [31:0] half_sel(input logic [63:0] w, input logic hi);
    return hi ? w[63:32] : w[31:0];
  endfunction
endpackage

// File: rtl/hififo_fpc_unpack.sv
// hififo_fpc_unpack: pops 64-bit FIFO words and streams them as framed 32-bit words
module hififo_fpc_unpack
  import hififo_pkg::*;
#(
  parameter int LEN_BITS  = 16,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [LEN_BITS-1:0] frame_len,
  input  logic [63:0]         fifo_data,
  input  logic                fifo_ready,
  output logic                fifo_rw,
  output logic [31:0]         m_tdata,
  output logic                m_tvalid,
  output logic                m_tlast,
  input  logic                m_tready,
  output logic [LEN_BITS-1:0] word_count,
  output logic [15:0]         frame_count
);
  state_t state, state_nx;
  logic [63:0] hold;
  logic [LEN_BITS-1:0] len_q, len_eff;
  logic last_now, xfer;
  // frame length is taken live on the first word so a fresh frame_len applies immediately
  always_comb begin
    len_eff  = (word_count == '0) ? frame_len : len_q;
    last_now = (len_eff != '0) && (word_count == len_eff - 1'b1);
    m_tvalid = state != EMPTY;
    m_tlast  = last_now && m_tvalid;
    m_tdata  = m_tvalid ? half_sel(hold, (state == SECOND) == LOW_FIRST) : '0;
    xfer     = m_tvalid && m_tready;
    fifo_rw  = reset_n && fifo_ready && enable &&
               (state == EMPTY || (state == SECOND && m_tready) ||
                (state == FIRST && m_tready && last_now));
  end
  // next state: a pop always reloads FIRST; a last word in FIRST skips the high half
  always_comb begin
    state_nx = state;
    if (fifo_rw) state_nx = FIRST;
    else if (xfer) state_nx = (state == FIRST && !last_now) ? SECOND : EMPTY;
  end
  // state and holding register, which doubles as the output skid stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      hold  <= '0;
    end else begin
      state <= state_nx;
      if (fifo_rw) hold <= fifo_data;
    end
  end
  // frame bookkeeping on every accepted output word
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_count  <= '0;
      frame_count <= '0;
      len_q       <= '0;
    end else if (xfer) begin
      if (word_count == '0) len_q <= frame_len;
      word_count <= last_now ? '0 : word_count + 1'b1;
      if (last_now) frame_count <= frame_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_hififo_fpc_unpack.sv
// tb_hififo_fpc_unpack: directed checks of unpacking, framing, backpressure and reset
module tb_hififo_fpc_unpack;
  logic clock = 0, reset_n = 0, enable = 1, m_tready = 1;
  logic [15:0] frame_len = 0;
  logic fifo_ready, fifo_rw, m_tvalid, m_tlast;
  logic [63:0] fifo_data;
  logic [31:0] m_tdata;
  logic [15:0] word_count, frame_count;
  logic fifo_ready2 = 0, fifo_rw2, m_tvalid2, m_tlast2;
  logic [63:0] fifo_data2 = 0;
  logic [31:0] m_tdata2;
  logic [15:0] word_count2, frame_count2;
  logic [63:0] mem [64];
  logic [5:0] wr = 0, rd = 0;
  logic flush = 0;
  int errors = 0, checks = 0;
  logic [31:0] rx_d[$];
  logic rx_l[$];
  logic [15:0] rx_w[$];
  logic prev_stall = 0, prev_l = 0;
  logic [31:0] prev_d = 0;
  logic [31:0] exp_d[$];
  logic exp_l[$];
  logic [31:0] pat = 32'hB4D26A39;

  hififo_fpc_unpack dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .frame_len(frame_len),
    .fifo_data(fifo_data), .fifo_ready(fifo_ready), .fifo_rw(fifo_rw),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .word_count(word_count), .frame_count(frame_count)
  );
  hififo_fpc_unpack #(.LEN_BITS(16), .LOW_FIRST(1'b0)) dut_hf (
    .clock(clock), .reset_n(reset_n), .enable(1'b1), .frame_len(16'd0),
    .fifo_data(fifo_data2), .fifo_ready(fifo_ready2), .fifo_rw(fifo_rw2),
    .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tlast(m_tlast2), .m_tready(1'b1),
    .word_count(word_count2), .frame_count(frame_count2)
  );

  always #5 clock = ~clock;

  // first-word-fall-through FIFO model
  assign fifo_ready = rd != wr;
  assign fifo_data  = mem[rd];
  always @(posedge clock) begin
    if (flush) rd <= wr;
    else if (fifo_rw) rd <= rd + 6'd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // output monitor: records transfers and checks stall stability
  always @(negedge clock) begin
    if (!reset_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", m_tvalid, 1);
        chk("stall_data", m_tdata, prev_d);
        chk("stall_last", m_tlast, prev_l);
      end
      if (m_tvalid && !m_tready) chk("stall_pop", fifo_rw, 0);
      if (m_tvalid && m_tready) begin
        rx_d.push_back(m_tdata);
        rx_l.push_back(m_tlast);
        rx_w.push_back(word_count);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
    end
  end

  task automatic push(input logic [63:0] w);
    mem[wr] = w;
    wr = wr + 6'd1;
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset_n = 0;
    flush = 1;
    repeat (2) @(posedge clock);
    #1 flush = 0;
    rx_d.delete();
    rx_l.delete();
    rx_w.delete();
  endtask

  task automatic rel;
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int c = 0;
    while (rx_d.size() < n && c < budget) begin
      @(posedge clock);
      c++;
    end
    chk(tag, rx_d.size(), n);
  endtask

  initial begin
    // reset state and continuous unframed stream
    do_reset;
    for (int i = 0; i < 4; i++) push(64'h11111111_00000000 + i);
    #1;
    chk("rst_rw", fifo_rw, 0);
    chk("rst_valid", m_tvalid, 0);
    chk("rst_last", m_tlast, 0);
    chk("rst_data", m_tdata, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_fc", frame_count, 0);
    rel;
    #1 chk("first_pop", fifo_rw, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("s_valid", m_tvalid, 1);
      chk("s_data", m_tdata, (i % 2) ? 32'h11111111 : 32'(i / 2));
      chk("s_last", m_tlast, 0);
      chk("s_rw", fifo_rw, (i % 2 == 1) && (i < 7));
    end
    @(negedge clock);
    chk("s_idle", m_tvalid, 0);
    chk("s_wc", word_count, 8);
    chk("s_fc", frame_count, 0);

    // six-word frames
    do_reset;
    frame_len = 6;
    for (int i = 0; i < 6; i++) push({32'hF0000000 + 32'(2 * i + 1), 32'hF0000000 + 32'(2 * i)});
    rel;
    wait_rx(12, 60, "f_count");
    for (int i = 0; i < 12 && i < rx_d.size(); i++) begin
      chk("f_data", rx_d[i], 32'hF0000000 + 32'(i));
      chk("f_last", rx_l[i], i == 5 || i == 11);
    end
    @(negedge clock);
    chk("f_fc", frame_count, 2);
    chk("f_wc", word_count, 0);

    // odd length drops the high half; enable low blocks pops
    do_reset;
    frame_len = 3;
    enable = 0;
    push(64'hA1A1A1A1_A0A0A0A0);
    push(64'hB1B1B1B1_B0B0B0B0);
    push(64'hC1C1C1C1_C0C0C0C0);
    push(64'hD1D1D1D1_D0D0D0D0);
    rel;
    repeat (3) @(negedge clock);
    chk("en_rw", fifo_rw, 0);
    chk("en_valid", m_tvalid, 0);
    @(posedge clock);
    #1 enable = 1;
    wait_rx(6, 40, "o_count");
    exp_d = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hB0B0B0B0, 32'hC0C0C0C0, 32'hC1C1C1C1, 32'hD0D0D0D0};
    exp_l = '{0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 6 && i < rx_d.size(); i++) begin
      chk("o_data", rx_d[i], exp_d[i]);
      chk("o_last", rx_l[i], exp_l[i]);
    end
    @(negedge clock);
    chk("o_fc", frame_count, 2);
    chk("o_valid", m_tvalid, 0);

    // backpressure with five-word frames
    do_reset;
    frame_len = 5;
    exp_d.delete();
    exp_l.delete();
    begin
      int k = 0;
      for (int i = 0; i < 8; i++) begin
        logic [63:0] w;
        w = {32'hB0000000 + 32'(2 * i + 1), 32'hB0000000 + 32'(2 * i)};
        push(w);
        exp_d.push_back(w[31:0]);
        k++;
        exp_l.push_back(k == 5);
        if (k == 5) k = 0;
        else begin
          exp_d.push_back(w[63:32]);
          k++;
          exp_l.push_back(k == 5);
          if (k == 5) k = 0;
        end
      end
    end
    rel;
    begin
      int c = 0;
      while (rx_d.size() < 14 && c < 300) begin
        @(posedge clock);
        #1 m_tready = pat[c % 32];
        c++;
      end
    end
    m_tready = 1;
    chk("b_count", rx_d.size(), 14);
    for (int i = 0; i < 14 && i < rx_d.size(); i++) begin
      chk("b_data", rx_d[i], exp_d[i]);
      chk("b_last", rx_l[i], exp_l[i]);
    end
    @(negedge clock);
    chk("b_fc", frame_count, 2);
    chk("b_wc", word_count, 4);

    // reset in the middle of a frame
    do_reset;
    frame_len = 6;
    for (int i = 0; i < 6; i++) push({32'h50000000 + 32'(2 * i + 1), 32'h50000000 + 32'(2 * i)});
    rel;
    wait_rx(3, 30, "r_pre");
    #1 reset_n = 0;
    flush = 1;
    #1;
    chk("r_valid", m_tvalid, 0);
    chk("r_last", m_tlast, 0);
    chk("r_wc", word_count, 0);
    chk("r_fc", frame_count, 0);
    chk("r_rw", fifo_rw, 0);
    repeat (2) @(posedge clock);
    #1 flush = 0;
    rx_d.delete();
    rx_l.delete();
    rx_w.delete();
    for (int i = 0; i < 6; i++) push({32'h60000000 + 32'(2 * i + 1), 32'h60000000 + 32'(2 * i)});
    rel;
    wait_rx(12, 60, "r_count");
    for (int i = 0; i < 12 && i < rx_d.size(); i++) begin
      chk("r_data", rx_d[i], 32'h60000000 + 32'(i));
      chk("r_tlast", rx_l[i], i == 5 || i == 11);
      chk("r_wcnt", rx_w[i], 16'(i % 6));
    end
    @(negedge clock);
    chk("r_fc_end", frame_count, 2);

    // high half first variant
    do_reset;
    fifo_data2 = 64'h22222222_11111111;
    fifo_ready2 = 1;
    rel;
    #1 chk("h_pop", fifo_rw2, 1);
    @(posedge clock);
    #1 fifo_ready2 = 0;
    @(negedge clock);
    chk("h_valid", m_tvalid2, 1);
    chk("h_first", m_tdata2, 32'h22222222);
    @(negedge clock);
    chk("h_second", m_tdata2, 32'h11111111);
    @(negedge clock);
    chk("h_idle", m_tvalid2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
